// File: rtl/lsu_pkg.sv
// lsu_pkg: shared encodings for the parametrised load/store unit.
// Op codes, error codes, FSM states and access helpers.
package lsu_pkg;

  localparam logic [3:0] LSU_LB   = 4'd0;
  localparam logic [3:0] LSU_LH   = 4'd1;
  localparam logic [3:0] LSU_LW   = 4'd2;
  localparam logic [3:0] LSU_LBU  = 4'd3;
  localparam logic [3:0] LSU_LHU  = 4'd4;
  localparam logic [3:0] LSU_SB   = 4'd5;
  localparam logic [3:0] LSU_SH   = 4'd6;
  localparam logic [3:0] LSU_SW   = 4'd7;
  localparam logic [3:0] LSU_NONE = 4'd8;
  localparam logic [3:0] LSU_LD   = 4'd9;
  localparam logic [3:0] LSU_LWU  = 4'd10;
  localparam logic [3:0] LSU_SD   = 4'd11;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_BUS      = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_AWW,
    S_B,
    S_RESP
  } lsu_state_t;

  function automatic logic [2:0] size_of(input logic [3:0] op);
    case (op)
      LSU_LH, LSU_LHU, LSU_SH: return 3'd1;
      LSU_LW, LSU_LWU, LSU_SW: return 3'd2;
      LSU_LD, LSU_SD:          return 3'd3;
      default:                 return 3'd0;
    endcase
  endfunction

  function automatic logic is_load(input logic [3:0] op);
    return op inside {LSU_LB, LSU_LH, LSU_LW, LSU_LBU,
                      LSU_LHU, LSU_LD, LSU_LWU};
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return op inside {LSU_SB, LSU_SH, LSU_SW, LSU_SD};
  endfunction

  // SLVERR and DECERR both count as a bus error
  function automatic logic bus_err(input logic [1:0] resp);
    return resp inside {2'b10, 2'b11};
  endfunction

endpackage

// File: rtl/lsu_axi_param_lane_align.sv
// lsu_lane_align: byte-lane steering between register and bus.
// Load extract/extend and store shift/strobe generation.
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int STRB_W = DATA_W / 8,
  parameter int OFF_W  = $clog2(STRB_W)
) (
  input  logic [3:0]        i_op,
  input  logic [OFF_W-1:0]  i_off,
  input  logic [DATA_W-1:0] i_rdata,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_ldata,
  output logic [DATA_W-1:0] o_wdata,
  output logic [STRB_W-1:0] o_wstrb
);

  logic [OFF_W+2:0]  w_bits;
  logic [DATA_W-1:0] w_rsh;
  logic [7:0]        w_mask;

  assign w_bits = {i_off, 3'b000};
  assign w_rsh  = i_rdata >> w_bits;

  // pick the addressed lane and sign/zero extend it
  always_comb begin
    o_ldata = w_rsh;
    case (i_op)
      LSU_LB:  o_ldata = DATA_W'(signed'(w_rsh[7:0]));
      LSU_LH:  o_ldata = DATA_W'(signed'(w_rsh[15:0]));
      LSU_LW:  o_ldata = DATA_W'(signed'(w_rsh[31:0]));
      LSU_LBU: o_ldata = DATA_W'(w_rsh[7:0]);
      LSU_LHU: o_ldata = DATA_W'(w_rsh[15:0]);
      LSU_LWU: o_ldata = DATA_W'(w_rsh[31:0]);
      default: o_ldata = w_rsh;
    endcase
  end

  // byte mask for the access size before lane shift
  always_comb begin
    case (size_of(i_op))
      3'd0:    w_mask = 8'h01;
      3'd1:    w_mask = 8'h03;
      3'd2:    w_mask = 8'h0F;
      default: w_mask = 8'hFF;
    endcase
  end

  assign o_wdata = i_wdata << w_bits;
  assign o_wstrb = STRB_W'(w_mask) << i_off;

endmodule

// File: rtl/lsu_axi_param.sv
// lsu_axi_param: single-beat AXI load/store unit, EXU to WBU.
// Traps misalignment locally, reports bus errors, holds under backpressure.
module lsu_axi_param
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int STRB_W = DATA_W / 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_wdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_rdata,
  output logic [1:0]        out_err,
  output logic              arvalid,
  input  logic              arready,
  output logic [ADDR_W-1:0] araddr,
  output logic [2:0]        arsize,
  input  logic              rvalid,
  output logic              rready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  output logic              awvalid,
  input  logic              awready,
  output logic [ADDR_W-1:0] awaddr,
  output logic [2:0]        awsize,
  output logic              wvalid,
  input  logic              wready,
  output logic [DATA_W-1:0] wdata,
  output logic [STRB_W-1:0] wstrb,
  input  logic              bvalid,
  output logic              bready,
  input  logic [1:0]        bresp
);

  localparam int OFF_W = $clog2(STRB_W);

  lsu_state_t        r_state;
  logic [3:0]        r_op;
  logic [OFF_W-1:0]  r_off;
  logic              r_in_ready;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_rdata;
  logic [1:0]        r_err;
  logic              r_arvalid;
  logic [ADDR_W-1:0] r_araddr;
  logic [2:0]        r_arsize;
  logic              r_rready;
  logic              r_awvalid;
  logic [ADDR_W-1:0] r_awaddr;
  logic [2:0]        r_awsize;
  logic              r_wvalid;
  logic [DATA_W-1:0] r_wdata;
  logic [STRB_W-1:0] r_wstrb;
  logic              r_bready;

  logic [3:0]        w_op;
  logic [OFF_W-1:0]  w_off;
  logic [DATA_W-1:0] w_ldata;
  logic [DATA_W-1:0] w_sdata;
  logic [STRB_W-1:0] w_sstrb;
  logic [ADDR_W-1:0] w_align;
  logic [2:0]        w_size;
  logic              w_bad;
  logic              w_aw_done;
  logic              w_w_done;

  // steer on the live request while idle, on the held one after
  assign w_op    = (r_state == S_IDLE) ? in_op : r_op;
  assign w_off   = (r_state == S_IDLE) ? in_addr[OFF_W-1:0] : r_off;
  assign w_align = {in_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign w_size  = size_of(in_op);

  assign w_aw_done = !r_awvalid || awready;
  assign w_w_done  = !r_wvalid || wready;

  lsu_lane_align #(
    .DATA_W (DATA_W),
    .STRB_W (STRB_W),
    .OFF_W  (OFF_W)
  ) u_align (
    .i_op    (w_op),
    .i_off   (w_off),
    .i_rdata (rdata),
    .i_wdata (in_wdata),
    .o_ldata (w_ldata),
    .o_wdata (w_sdata),
    .o_wstrb (w_sstrb)
  );

  // trap misaligned, unknown and too-wide ops before any bus access
  always_comb begin
    w_bad = 1'b0;
    unique case (1'b1)
      (w_size == 3'd1): w_bad = in_addr[0];
      (w_size == 3'd2): w_bad = |in_addr[1:0];
      (w_size == 3'd3): w_bad = |in_addr[2:0];
      default:          w_bad = 1'b0;
    endcase
    if (DATA_W == 32 && in_op inside {LSU_LD, LSU_LWU, LSU_SD})
      w_bad = 1'b1;
    if (!is_load(in_op) && !is_store(in_op) && in_op != LSU_NONE)
      w_bad = 1'b1;
  end

  // request/response sequencing and AXI channel drive
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_op        <= LSU_NONE;
      r_off       <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_rdata     <= '0;
      r_err       <= ERR_OK;
      r_arvalid   <= 1'b0;
      r_araddr    <= '0;
      r_arsize    <= '0;
      r_rready    <= 1'b0;
      r_awvalid   <= 1'b0;
      r_awaddr    <= '0;
      r_awsize    <= '0;
      r_wvalid    <= 1'b0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_bready    <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_in_ready <= 1'b1;
          if (in_valid && r_in_ready) begin
            r_in_ready <= 1'b0;
            r_op       <= in_op;
            r_off      <= in_addr[OFF_W-1:0];
            if (in_op == LSU_NONE || w_bad) begin
              r_state     <= S_RESP;
              r_out_valid <= 1'b1;
              r_rdata     <= '0;
              r_err       <= w_bad ? ERR_MISALIGN : ERR_OK;
            end else if (is_load(in_op)) begin
              r_state   <= S_AR;
              r_arvalid <= 1'b1;
              r_araddr  <= w_align;
              r_arsize  <= w_size;
            end else begin
              r_state   <= S_AWW;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_awaddr  <= w_align;
              r_awsize  <= w_size;
              r_wdata   <= w_sdata;
              r_wstrb   <= w_sstrb;
            end
          end
        end
        S_AR: begin
          if (arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_R;
          end
        end
        S_R: begin
          if (rvalid) begin
            r_rready    <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= S_RESP;
            r_err       <= bus_err(rresp) ? ERR_BUS : ERR_OK;
            r_rdata     <= bus_err(rresp) ? '0 : w_ldata;
          end
        end
        S_AWW: begin
          if (w_aw_done && w_w_done) begin
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b1;
            r_state   <= S_B;
          end else begin
            if (awready) r_awvalid <= 1'b0;
            if (wready)  r_wvalid  <= 1'b0;
          end
        end
        S_B: begin
          if (bvalid) begin
            r_bready    <= 1'b0;
            r_out_valid <= 1'b1;
            r_rdata     <= '0;
            r_err       <= bus_err(bresp) ? ERR_BUS : ERR_OK;
            r_state     <= S_RESP;
          end
        end
        S_RESP: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_rdata     <= '0;
            r_err       <= ERR_OK;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_rdata = r_rdata;
  assign out_err   = r_err;
  assign arvalid   = r_arvalid;
  assign araddr    = r_araddr;
  assign arsize    = r_arsize;
  assign rready    = r_rready;
  assign awvalid   = r_awvalid;
  assign awaddr    = r_awaddr;
  assign awsize    = r_awsize;
  assign wvalid    = r_wvalid;
  assign wdata     = r_wdata;
  assign wstrb     = r_wstrb;
  assign bready    = r_bready;

endmodule
